// File: rtl/ifm_stream_reader_pkg.sv
// Shared definitions for the IFM stream reader: map-size table, sel codes,
// FSM encoding and the nibble-unpack helper.
package ifm_stream_reader_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 4;

    localparam int LEN1_DEF = 16;
    localparam int LEN2_DEF = 14;
    localparam int LEN3_DEF = 28;
    localparam int LEN4_DEF = 56;
    localparam int LEN5_DEF = 112;
    localparam int LEN6_DEF = 224;

    localparam logic [2:0] SEL_16  = 3'd0;
    localparam logic [2:0] SEL_14  = 3'd1;
    localparam logic [2:0] SEL_28  = 3'd2;
    localparam logic [2:0] SEL_56  = 3'd3;
    localparam logic [2:0] SEL_112 = 3'd4;
    localparam logic [2:0] SEL_224 = 3'd5;

    typedef logic [5:0][7:0] len_tab_t;
    typedef logic [NUM_CH-1:0][CH_W-1:0] pix_t;

    localparam len_tab_t LEN_TAB_DEF = {8'(LEN6_DEF), 8'(LEN5_DEF), 8'(LEN4_DEF),
                                        8'(LEN3_DEF), 8'(LEN2_DEF), 8'(LEN1_DEF)};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Zero marks an invalid code so callers can use it as the error test.
    function automatic logic [7:0] len_of_sel(input logic [2:0] sel,
                                              input len_tab_t tab = LEN_TAB_DEF);
        logic [7:0] len;
        case (sel)
            SEL_16:  len = tab[0];
            SEL_14:  len = tab[1];
            SEL_28:  len = tab[2];
            SEL_56:  len = tab[3];
            SEL_112: len = tab[4];
            SEL_224: len = tab[5];
            default: len = 8'd0;
        endcase
        return len;
    endfunction

    function automatic pix_t unpack_nibbles(input logic [31:0] word);
        return pix_t'(word);
    endfunction

endpackage

// File: rtl/ifm_stream_outreg.sv
// Output stage: one-word skid buffer that catches a read landing during pause,
// plus the registered channel data, beat strobe and sof/eol flags.
module ifm_stream_outreg
    import ifm_stream_reader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_pending,
    input  logic        pause,
    input  logic [31:0] rdata,
    input  logic        sof_in,
    input  logic        eol_in,
    output logic        fire,
    output logic        out_valid,
    output pix_t        pix,
    output logic        sof,
    output logic        eol
);

    logic [31:0] skid;
    logic        skid_v;

    // A beat leaves this edge when unpaused and either a fresh word or a skid word exists.
    assign fire = !pause && (rd_pending || skid_v);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid      <= '0;
            skid_v    <= 1'b0;
            pix       <= '0;
            out_valid <= 1'b0;
            sof       <= 1'b0;
            eol       <= 1'b0;
        end else begin
            out_valid <= fire;
            sof       <= fire && sof_in;
            eol       <= fire && eol_in;
            if (rd_pending && pause) begin
                skid   <= rdata;
                skid_v <= 1'b1;
            end else if (rd_pending) begin
                pix <= unpack_nibbles(rdata);
            end else if (skid_v && !pause) begin
                pix    <= unpack_nibbles(skid);
                skid_v <= 1'b0;
            end
        end
    end

    // Skid only fills while pause blocks new reads, so it is always drained first.
    a_no_skid_collision: assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_pending && skid_v));

endmodule

// File: rtl/ifm_stream_reader.sv
// Raster-order feature-map reader feeding the 3x3 line-buffer collector with
// eight 4-bit channel streams; map side chosen by the shared sel code.
module ifm_stream_reader
    import ifm_stream_reader_pkg::*;
#(
    parameter int LEN1 = LEN1_DEF,
    parameter int LEN2 = LEN2_DEF,
    parameter int LEN3 = LEN3_DEF,
    parameter int LEN4 = LEN4_DEF,
    parameter int LEN5 = LEN5_DEF,
    parameter int LEN6 = LEN6_DEF,
    parameter int AW   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [2:0]    sel,
    input  logic          pause,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [31:0]   mem_rdata,
    output logic          out_valid,
    output logic [3:0]    ifmstream_0,
    output logic [3:0]    ifmstream_1,
    output logic [3:0]    ifmstream_2,
    output logic [3:0]    ifmstream_3,
    output logic [3:0]    ifmstream_4,
    output logic [3:0]    ifmstream_5,
    output logic [3:0]    ifmstream_6,
    output logic [3:0]    ifmstream_7,
    output logic          sof,
    output logic          eol,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam len_tab_t LEN_TAB = {8'(LEN6), 8'(LEN5), 8'(LEN4),
                                    8'(LEN3), 8'(LEN2), 8'(LEN1)};
    // One extra bit so rd_cnt can reach N itself and stop the read issue.
    localparam int CW = AW + 1;

    state_t        state;
    logic [7:0]    len;
    logic [7:0]    col;
    logic [7:0]    row;
    logic [CW-1:0] n_pix;
    logic [CW-1:0] rd_cnt;
    logic          rd_pending;
    logic          fire;
    logic          fin;
    logic [7:0]    sel_len;
    logic          sof_in;
    logic          eol_in;
    logic          last_beat;
    pix_t          pix;

    assign sel_len   = len_of_sel(sel, LEN_TAB);
    assign mem_rd_en = (state == ST_RUN) && !pause && (rd_cnt < n_pix);
    assign mem_addr  = rd_cnt[AW-1:0];
    assign sof_in    = (row == 8'd0) && (col == 8'd0);
    assign eol_in    = (col == len - 8'd1);
    assign last_beat = fire && eol_in && (row == len - 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_pending <= 1'b0;
        else        rd_pending <= mem_rd_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            len    <= '0;
            n_pix  <= '0;
            rd_cnt <= '0;
            col    <= '0;
            row    <= '0;
            fin    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (sel_len != 8'd0) begin
                            len    <= sel_len;
                            n_pix  <= CW'(sel_len) * CW'(sel_len);
                            rd_cnt <= '0;
                            col    <= '0;
                            row    <= '0;
                            fin    <= 1'b0;
                            busy   <= 1'b1;
                            state  <= ST_RUN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (mem_rd_en) rd_cnt <= rd_cnt + CW'(1);
                    // Position tracks emitted beats, so pauses never skew sof/eol.
                    if (fire) begin
                        if (eol_in) begin
                            col <= '0;
                            row <= row + 8'd1;
                        end else begin
                            col <= col + 8'd1;
                        end
                    end
                    if (last_beat) fin <= 1'b1;
                    if (fin) begin
                        state  <= ST_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        rd_cnt <= '0;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    ifm_stream_outreg u_outreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_pending (rd_pending),
        .pause      (pause),
        .rdata      (mem_rdata),
        .sof_in     (sof_in),
        .eol_in     (eol_in),
        .fire       (fire),
        .out_valid  (out_valid),
        .pix        (pix),
        .sof        (sof),
        .eol        (eol)
    );

    assign ifmstream_0 = pix[0];
    assign ifmstream_1 = pix[1];
    assign ifmstream_2 = pix[2];
    assign ifmstream_3 = pix[3];
    assign ifmstream_4 = pix[4];
    assign ifmstream_5 = pix[5];
    assign ifmstream_6 = pix[6];
    assign ifmstream_7 = pix[7];

endmodule

// File: tb/tb_ifm_stream_reader.sv
// Bench for ifm_stream_reader: frame-level model of the expected beat stream
// checked every cycle, plus directed pause, error, reset and back-to-back cases.
module tb_ifm_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic        pause = 1'b0;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata = 32'd0;
    logic        out_valid;
    logic [3:0]  ifmstream_0, ifmstream_1, ifmstream_2, ifmstream_3;
    logic [3:0]  ifmstream_4, ifmstream_5, ifmstream_6, ifmstream_7;
    logic        sof, eol, busy, done, err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int lens [6] = '{16, 14, 28, 56, 112, 224};

    // Frame model: expected beat k carries word(k); reads must be 0..N-1 in order.
    int m_len = 1, m_n = 0, m_beat = 0, m_rd = 0;
    int m_first_rd = -1, m_first_v = -1, m_last_v = -1;
    int m_done_cnt = 0, m_sof_cnt = 0, m_eol_cnt = 0, m_last_addr = -1;
    bit m_prev_pause = 1'b0;

    wire [31:0] stream = {ifmstream_7, ifmstream_6, ifmstream_5, ifmstream_4,
                          ifmstream_3, ifmstream_2, ifmstream_1, ifmstream_0};

    ifm_stream_reader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .sel         (sel),
        .pause       (pause),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .out_valid   (out_valid),
        .ifmstream_0 (ifmstream_0),
        .ifmstream_1 (ifmstream_1),
        .ifmstream_2 (ifmstream_2),
        .ifmstream_3 (ifmstream_3),
        .ifmstream_4 (ifmstream_4),
        .ifmstream_5 (ifmstream_5),
        .ifmstream_6 (ifmstream_6),
        .ifmstream_7 (ifmstream_7),
        .sof         (sof),
        .eol         (eol),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word(input int a);
        logic [15:0] a16;
        a16 = a[15:0];
        return {a16 ^ 16'h5A3C, a16};
    endfunction

    always @(posedge clk) if (mem_rd_en) mem_rdata <= word(int'(mem_addr));

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd_en) begin
                check(int'(mem_addr) == m_rd && m_rd < m_n, "rd_addr", mem_addr, m_rd);
                check(!pause, "rd_while_pause", pause, 0);
                if (m_rd == 0) m_first_rd = cyc;
                m_last_addr = int'(mem_addr);
                m_rd++;
            end
            if (out_valid) begin
                check(stream == word(m_beat), "beat_data", stream, word(m_beat));
                check(sof == (m_beat == 0), "sof", sof, m_beat == 0);
                check(eol == (m_beat % m_len == m_len - 1), "eol", eol, m_beat % m_len == m_len - 1);
                check(!m_prev_pause && busy && m_beat < m_n, "beat_ctx", m_beat, m_n);
                if (m_beat == 0) m_first_v = cyc;
                if (sof) m_sof_cnt++;
                if (eol) m_eol_cnt++;
                m_last_v = cyc;
                m_beat++;
            end
            if (done) begin
                check(m_beat == m_n && m_last_v == cyc - 1 && !busy, "done_timing", m_beat, m_n);
                m_done_cnt++;
            end
        end
        m_prev_pause = pause;
    end

    task automatic model_init(input int s);
        m_len = lens[s]; m_n = m_len * m_len;
        m_beat = 0; m_rd = 0; m_first_rd = -1; m_first_v = -1; m_last_v = -1;
        m_done_cnt = 0; m_sof_cnt = 0; m_eol_cnt = 0; m_last_addr = -1;
    endtask

    // Called at posedge+1; the start is sampled at the next edge.
    task automatic start_frame(input int s);
        sel = 3'(s);
        start = 1'b1;
        model_init(s);
        @(posedge clk); #1;
        start = 1'b0;
        sel = 3'd7;
        check(busy == 1'b1, "busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input int maxc, input bit toggle);
        int k = 0;
        while (m_done_cnt == 0 && k < maxc) begin
            @(posedge clk); #1;
            if (toggle) pause = ~pause;
            k++;
        end
        pause = 1'b0;
        check(m_done_cnt == 1, "done_wait", m_done_cnt, 1);
    endtask

    task automatic end_checks(input int n, input int rows);
        check(m_beat == n, "beat_count", m_beat, n);
        check(m_rd == n, "read_count", m_rd, n);
        check(m_last_addr == n - 1, "last_addr", m_last_addr, n - 1);
        check(m_eol_cnt == rows && m_sof_cnt == 1, "eol_count", m_eol_cnt, rows);
        check(busy == 1'b0 && done == 1'b0, "idle_after_done", {busy, done}, 0);
    endtask

    task automatic check_zero(input string name);
        check({out_valid, busy, done, err, mem_rd_en, sof, eol} == 7'd0, name, {out_valid, busy, done, err, mem_rd_en, sof, eol}, 0);
        check(stream == 32'd0 && mem_addr == 16'd0, {name, "_data"}, stream, 0);
    endtask

    initial begin
        bit seen;
        int k;

        repeat (2) @(posedge clk); #1;
        check_zero("reset_state");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 14x14, no pause
        start_frame(1);
        wait_done(196 * 3 + 50, 1'b0);
        end_checks(196, 14);
        check(m_first_v - m_first_rd == 2, "first_latency", m_first_v - m_first_rd, 2);

        // 16x16 with a 3-cycle pause right after a read
        start_frame(0);
        repeat (20) begin @(posedge clk); #1; end
        check(mem_rd_en == 1'b1, "rd_before_pause", mem_rd_en, 1);
        @(posedge clk); #1;
        pause = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        pause = 1'b0;
        wait_done(256 * 3 + 50, 1'b0);
        end_checks(256, 16);

        // 28x28 with pause toggling every cycle
        start_frame(2);
        wait_done(784 * 3 + 50, 1'b1);
        end_checks(784, 28);

        // invalid sel codes
        for (int s = 6; s < 8; s++) begin
            sel = 3'(s);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            sel = 3'd0;
            check(err == 1'b1, "err_pulse", err, 1);
            seen = 1'b0;
            repeat (4) begin
                @(posedge clk); #1;
                if (err || busy || mem_rd_en) seen = 1'b1;
            end
            check(!seen, "err_side_effects", seen, 0);
        end

        // second start while running is ignored
        start_frame(0);
        repeat (30) begin @(posedge clk); #1; end
        sel = 3'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(256 * 3 + 50, 1'b0);
        end_checks(256, 16);

        // reset mid-frame with the skid buffer full
        start_frame(3);
        k = 0;
        while (m_beat < 50 && k < 500) begin @(posedge clk); #1; k++; end
        check(m_beat >= 50, "reach_beat50", m_beat, 50);
        pause = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1 check_zero("midframe_reset");
        pause = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_frame(3);
        wait_done(3136 * 3 + 50, 1'b0);
        end_checks(3136, 56);

        // back-to-back 224x224 frame on the cycle after done
        start_frame(5);
        wait_done(50176 + 200, 1'b0);
        end_checks(50176, 224);
        check(m_last_addr == 50175, "final_addr", m_last_addr, 50175);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
